// File: rtl/quad_gen_pkg.sv
// Shared types and phase tables for the quadrature encoder emulator.
package pkg_quad_gen;

   localparam int Q_DWELL_W = 20;
   localparam int Q_STEP_W  = 8;

   typedef enum logic [1:0] {IDLE, PHASE, DONE, PRESS} q_state_e;

   typedef struct packed {
      logic                 dir;
      logic [Q_STEP_W-1:0]  steps;
      logic [Q_DWELL_W-1:0] dwell;
   } q_cmd;

   localparam logic [1:0] LINE_IDLE = 2'b11;

   // Index 0 is the first phase of a detent; entry 3 is always the idle level.
   localparam logic [3:0][1:0] CW_SEQ  = {2'b11, 2'b10, 2'b00, 2'b01};
   localparam logic [3:0][1:0] CCW_SEQ = {2'b11, 2'b01, 2'b00, 2'b10};

   function automatic logic [1:0] phase_level(input logic dir, input logic [1:0] ph);
      return dir ? CW_SEQ[ph] : CCW_SEQ[ph];
   endfunction

endpackage

// File: rtl/quad_gen_dwell_timer.sv
// Loadable down-counter shared by phase and press timing; holds at zero.
module quad_dwell_timer #(
   parameter int W = 22
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (en && value != '0)
         value <= value - W'(1);
   end

   assign zero = (value == '0);

endmodule

// File: rtl/quad_gen.sv
// Rotary-encoder emulator: turns step commands into ec_clk/ec_dt quadrature waveforms.
// Optional push-switch emulation (cmd_press/ec_sw, PRESS state) under QUAD_GEN_SW_EN.
module quad_gen
   import pkg_quad_gen::*;
#(
   parameter int DWELL_W = Q_DWELL_W,
   parameter int STEP_W  = Q_STEP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_dir,
   input  logic [STEP_W-1:0]  cmd_steps,
   input  logic [DWELL_W-1:0] cmd_dwell,
`ifdef QUAD_GEN_SW_EN
   input  logic               cmd_press,
   output logic               ec_sw,
`endif
   output logic               ec_clk,
   output logic               ec_dt,
   output logic               busy,
   output logic               done
);

   localparam int TW = DWELL_W + 2;

   q_state_e          state;
   q_cmd              cmd;
   logic              arm;
   logic [1:0]        phase;
   logic [1:0]        nxt_phase;
   logic [STEP_W-1:0] detent;
   logic [1:0]        lines;

   logic          tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0] tmr_val, tmr_value;
   logic [TW-1:0] dwell_m1;

   assign ec_clk    = lines[1];
   assign ec_dt     = lines[0];
   assign nxt_phase = phase + 2'd1;
   assign dwell_m1  = {2'b00, cmd.dwell} - TW'(1);

   always_comb begin
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = dwell_m1;
      case (state)
         PHASE: begin
            if (arm || tmr_zero) tmr_load = 1'b1;
            else                 tmr_en   = 1'b1;
         end
`ifdef QUAD_GEN_SW_EN
         PRESS: begin
            tmr_val = {cmd.dwell, 2'b00} - TW'(1);
            if (arm) tmr_load = 1'b1;
            else     tmr_en   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   quad_dwell_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .value    (tmr_value),
      .zero     (tmr_zero)
   );

   // arm marks the single setup cycle after accept, so the first level lands after edge 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd       <= '0;
         arm       <= 1'b0;
         phase     <= 2'd0;
         detent    <= '0;
         lines     <= LINE_IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef QUAD_GEN_SW_EN
         ec_sw     <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (cmd_valid) begin
                  cmd.dir   <= cmd_dir;
                  cmd.steps <= cmd_steps;
                  cmd.dwell <= (cmd_dwell == '0) ? DWELL_W'(1) : cmd_dwell;
                  arm       <= 1'b1;
                  phase     <= 2'd0;
                  detent    <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef QUAD_GEN_SW_EN
                  state     <= cmd_press ? PRESS : PHASE;
`else
                  state     <= PHASE;
`endif
               end
            end
            PHASE: begin
               if (arm) begin
                  arm <= 1'b0;
                  if (cmd.steps == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     lines <= phase_level(cmd.dir, 2'd0);
                  end
               end else if (tmr_zero) begin
                  phase <= nxt_phase;
                  if (phase == 2'd3) begin
                     detent <= detent + STEP_W'(1);
                     if (detent + STEP_W'(1) == cmd.steps) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        lines <= phase_level(cmd.dir, 2'd0);
                     end
                  end else begin
                     lines <= phase_level(cmd.dir, nxt_phase);
                  end
               end
            end
`ifdef QUAD_GEN_SW_EN
            PRESS: begin
               if (arm) begin
                  arm   <= 1'b0;
                  ec_sw <= 1'b0;
               end else if (tmr_zero) begin
                  ec_sw <= 1'b1;
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
`endif
            DONE: begin
               done      <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen; expected waveforms come from a timing-formula model.
module tb_quad_gen;

   localparam int DW = 20;
   localparam int SW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_dir = 1'b0;
   logic [SW-1:0] cmd_steps = '0;
   logic [DW-1:0] cmd_dwell = '0;
   logic          cmd_ready, ec_clk, ec_dt, busy, done;
`ifdef QUAD_GEN_SW_EN
   logic          cmd_press = 1'b0;
   logic          ec_sw;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   quad_gen #(.DWELL_W(DW), .STEP_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
      .cmd_dwell (cmd_dwell),
`ifdef QUAD_GEN_SW_EN
      .cmd_press (cmd_press),
      .ec_sw     (ec_sw),
`endif
      .ec_clk    (ec_clk),
      .ec_dt     (ec_dt),
      .busy      (busy),
      .done      (done)
   );

   // Expected (A,B) after edge t of a command accepted at edge 0.
   function automatic logic [1:0] ref_level(input bit dir, input int t, input int n, input int dw);
      int k;
      if (t < 1) return 2'b11;
      k = (t - 1) / dw;
      if (k >= 4 * n) return 2'b11;
      case (k % 4)
         0:       return dir ? 2'b01 : 2'b10;
         1:       return 2'b00;
         2:       return dir ? 2'b10 : 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   task automatic issue(input bit dir, input int steps, input int dwell);
      cmd_dir   = dir;
      cmd_steps = SW'(steps);
      cmd_dwell = DW'(dwell);
      cmd_valid = 1'b1;
   endtask

   // Call at a negedge with a command just offered; checks every cycle through ready return.
   task automatic check_run(input string name, input bit dir, input int n, input int dw,
                            input bit churn, input bit keep);
      int dwe, last;
      logic [1:0] prev, exp_l;
      bit exp_done, exp_rdy;
      dwe  = (dw == 0) ? 1 : dw;
      last = 2 + 4 * n * dwe;
      prev = 2'b11;
      for (int t = 0; t <= last; t++) begin
         @(negedge clk);
         exp_l    = ref_level(dir, t, n, dwe);
         exp_done = (t == 1 + 4 * n * dwe);
         exp_rdy  = (t >= last);
         checks++;
         if ({ec_clk, ec_dt} !== exp_l) begin
            errors++;
            $display("FAIL %s lines t=%0d got %b exp %b", name, t, {ec_clk, ec_dt}, exp_l);
         end
         checks++;
         if (done !== exp_done) begin
            errors++;
            $display("FAIL %s done t=%0d got %b exp %b", name, t, done, exp_done);
         end
         checks++;
         if (cmd_ready !== exp_rdy || busy !== !exp_rdy) begin
            errors++;
            $display("FAIL %s ready/busy t=%0d got %b/%b exp %b/%b", name, t, cmd_ready, busy,
                     exp_rdy, !exp_rdy);
         end
         checks++;
         if (({ec_clk, ec_dt} ^ prev) === 2'b11) begin
            errors++;
            $display("FAIL %s gray t=%0d got %b from %b", name, t, {ec_clk, ec_dt}, prev);
         end
         prev = {ec_clk, ec_dt};
         if (churn) begin
            cmd_steps = 8'd7;
            cmd_dir   = ~cmd_dir;
            cmd_dwell = DW'(1);
         end
         if (!keep) cmd_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ec_clk, ec_dt, cmd_ready, busy, done} !== 5'b11100) begin
         errors++;
         $display("FAIL reset outs got %b exp 11100", {ec_clk, ec_dt, cmd_ready, busy, done});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({ec_clk, ec_dt, cmd_ready, busy, done} !== 5'b11100) begin
         errors++;
         $display("FAIL post_reset idle got %b exp 11100", {ec_clk, ec_dt, cmd_ready, busy, done});
      end
   endtask

   task automatic test_single_cw();
      issue(1'b1, 1, 3);
      check_run("cw1", 1'b1, 1, 3, 1'b0, 1'b0);
   endtask

   task automatic test_ccw3();
      issue(1'b0, 3, 2);
      check_run("ccw3", 1'b0, 3, 2, 1'b0, 1'b0);
   endtask

   task automatic test_zero();
      issue(1'b1, 0, 5);
      check_run("zero_steps", 1'b1, 0, 5, 1'b0, 1'b0);
      issue(1'b0, 1, 0);
      check_run("zero_dwell", 1'b0, 1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 2, 2);
      check_run("hs_first", 1'b1, 2, 2, 1'b1, 1'b1);
      issue(1'b0, 1, 3);
      check_run("hs_second", 1'b0, 1, 3, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      bit d;
      int n, w;
      for (int i = 0; i < 10; i++) begin
         d = 1'($urandom_range(0, 1));
         n = int'($urandom_range(0, 4));
         w = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         issue(d, n, w);
         check_run("random", d, n, w, 1'b0, 1'b0);
      end
   endtask

   task automatic test_max_steps();
      issue(1'b1, 255, 1);
      check_run("steps255", 1'b1, 255, 1, 1'b0, 1'b0);
   endtask

   task automatic test_midrun_reset();
      issue(1'b1, 3, 2);
      for (int t = 0; t <= 19; t++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      checks++;
      if ({ec_clk, ec_dt} !== 2'b00) begin
         errors++;
         $display("FAIL midrst pre lines got %b exp 00", {ec_clk, ec_dt});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ec_clk, ec_dt, cmd_ready, busy, done} !== 5'b11100) begin
         errors++;
         $display("FAIL midrst async got %b exp 11100", {ec_clk, ec_dt, cmd_ready, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1'b1, 1, 2);
      check_run("after_rst", 1'b1, 1, 2, 1'b0, 1'b0);
   endtask

`ifdef QUAD_GEN_SW_EN
   task automatic test_press();
      bit exp_sw;
      cmd_press = 1'b1;
      issue(1'b0, 3, 5);
      for (int t = 0; t <= 22; t++) begin
         @(negedge clk);
         exp_sw = !(t >= 1 && t <= 20);
         checks++;
         if (ec_sw !== exp_sw || {ec_clk, ec_dt} !== 2'b11 || done !== (t == 21)
             || cmd_ready !== (t >= 22)) begin
            errors++;
            $display("FAIL press t=%0d got sw=%b ab=%b done=%b rdy=%b exp sw=%b ab=11 done=%b rdy=%b",
                     t, ec_sw, {ec_clk, ec_dt}, done, cmd_ready, exp_sw, (t == 21), (t >= 22));
         end
         cmd_valid = 1'b0;
         cmd_press = 1'b0;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_cw();
      test_ccw3();
      test_zero();
      test_back_to_back();
      test_random();
      test_max_steps();
      test_midrun_reset();
`ifdef QUAD_GEN_SW_EN
      test_press();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
